// File: rtl/ascon_sched_pkg.sv
// Shared types and helpers for the ASCON permutation scheduler.
package ascon_sched_pkg;

    typedef enum logic [1:0] {
        OP_INIT  = 2'd0,
        OP_AD    = 2'd1,
        OP_MSG   = 2'd2,
        OP_FINAL = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_DONE
    } state_e;

    localparam int ROUNDS_A_DEF = 12;
    localparam int ROUNDS_B_DEF = 6;

    // Shorter permutations use the tail of the 12-entry constant table.
    function automatic logic [3:0] rc_idx(input logic [3:0] n_rounds, input logic [3:0] cnt);
        return 4'd12 - n_rounds + cnt;
    endfunction

endpackage

// File: rtl/ascon_perm_sched_if.sv
// Request/grant handshake and permutation-core control bundle.
interface ascon_perm_sched_if #(
    parameter int NREQ = 2
);
    localparam int SEL_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req_valid;
    logic [2*NREQ-1:0] req_op;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   done;
    logic [SEL_W-1:0]  perm_sel;
    logic              perm_load;
    logic              perm_en;
    logic [3:0]        perm_rc_idx;

    modport master (
        output req_valid, req_op,
        input  req_ready, done, perm_sel, perm_load, perm_en, perm_rc_idx
    );

    modport slave (
        input  req_valid, req_op,
        output req_ready, done, perm_sel, perm_load, perm_en, perm_rc_idx
    );

endinterface

// File: rtl/ascon_perm_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first eligible requester at or after rr_ptr wins.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int SEL_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  mask,
    input  logic [SEL_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  grant
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        // Scan farthest-first so the candidate nearest rr_ptr overwrites the rest.
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(rr_ptr) + k) % NREQ;
            if (req[j] && mask[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ascon_perm_sched.sv
// Session-locking scheduler sharing one ASCON permutation core between NREQ requesters.
module ascon_perm_sched
    import ascon_sched_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int ROUNDS_A = ROUNDS_A_DEF,
    parameter int ROUNDS_B = ROUNDS_B_DEF
) (
    input  logic            ACLK,
    input  logic            ARESET,
    ascon_perm_sched_if.slave bus,
    output logic            busy,
    output logic            sess_open,
    output logic            err,
    input  logic            err_clr,
    input  logic [NREQ-1:0] irq_en,
    input  logic [NREQ-1:0] irq_ack,
    output logic [NREQ-1:0] irq_pend,
    output logic            irq
);

    localparam int SEL_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e            state_q, state_d;
    op_e               op_q, op_d, gnt_op;
    logic [SEL_W-1:0]  sel_q, sel_d, rr_q, rr_d;
    logic              sess_q, sess_d, err_q, err_d, irq_q, irq_d;
    logic [3:0]        cnt_q, cnt_d, n_rounds;
    logic [NREQ-1:0]   pend_q, pend_d, elig, grant;
    logic [NREQ-1:0]   ready_o, done_o;
    logic              load_o, en_o;
    logic [3:0]        rc_o;

    // While a session is open only its owner may issue jobs.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) elig[i] = !sess_q || (SEL_W'(i) == sel_q);
    end

    rr_arbiter #(.NREQ(NREQ), .SEL_W(SEL_W)) u_arb (
        .req    (bus.req_valid),
        .mask   (elig),
        .rr_ptr (rr_q),
        .grant  (grant)
    );

    always_comb begin
        n_rounds = (op_q == OP_INIT || op_q == OP_FINAL) ? 4'(ROUNDS_A) : 4'(ROUNDS_B);
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sel_d   = sel_q;
        sess_d  = sess_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        err_d   = err_q & ~err_clr;
        pend_d  = pend_q & ~irq_ack;
        irq_d   = |(pend_q & irq_en);
        ready_o = '0;
        done_o  = '0;
        load_o  = 1'b0;
        en_o    = 1'b0;
        rc_o    = '0;
        gnt_op  = OP_INIT;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) gnt_op = op_e'(bus.req_op[2*i +: 2]);
        end
        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    ready_o = grant;
                    op_d    = gnt_op;
                    for (int i = 0; i < NREQ; i++) begin
                        if (grant[i]) sel_d = SEL_W'(i);
                    end
                    if (sess_q) begin
                        state_d = ST_LOAD;
                    end else if (gnt_op == OP_INIT) begin
                        sess_d  = 1'b1;
                        state_d = ST_LOAD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                load_o  = 1'b1;
                cnt_d   = '0;
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                en_o = 1'b1;
                rc_o = rc_idx(n_rounds, cnt_q);
                if (cnt_q == n_rounds - 4'd1) state_d = ST_DONE;
                else                          cnt_d   = cnt_q + 4'd1;
            end
            ST_DONE: begin
                for (int i = 0; i < NREQ; i++) done_o[i] = (SEL_W'(i) == sel_q);
                // Applied after the ack clear so a same-cycle set wins.
                if (op_q == OP_FINAL) begin
                    sess_d        = 1'b0;
                    pend_d[sel_q] = 1'b1;
                    rr_d          = (sel_q == SEL_W'(NREQ - 1)) ? '0 : sel_q + SEL_W'(1);
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
            op_q    <= OP_INIT;
            sel_q   <= '0;
            rr_q    <= '0;
            sess_q  <= 1'b0;
            err_q   <= 1'b0;
            irq_q   <= 1'b0;
            cnt_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            sess_q  <= sess_d;
            err_q   <= err_d;
            irq_q   <= irq_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.req_ready   = ready_o;
    assign bus.done        = done_o;
    assign bus.perm_sel    = sel_q;
    assign bus.perm_load   = load_o;
    assign bus.perm_en     = en_o;
    assign bus.perm_rc_idx = rc_o;
    assign busy            = (state_q != ST_IDLE);
    assign sess_open       = sess_q;
    assign err             = err_q;
    assign irq_pend        = pend_q;
    assign irq             = irq_q;

endmodule

// File: tb/tb_ascon_perm_sched.sv
// Self-checking bench for ascon_perm_sched against a transaction-level session model.
module tb_ascon_perm_sched;

    localparam int NREQ  = 2;
    localparam int RA    = 12;
    localparam int RB    = 6;
    localparam int SEL_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int VW    = 2*NREQ + 6 + SEL_W;

    logic            ACLK = 1'b0;
    logic            ARESET = 1'b1;
    logic            busy, sess_open, err, irq;
    logic            err_clr = 1'b0;
    logic [NREQ-1:0] irq_en = '0;
    logic [NREQ-1:0] irq_ack = '0;
    logic [NREQ-1:0] irq_pend;

    ascon_perm_sched_if #(.NREQ(NREQ)) bus ();

    ascon_perm_sched #(.NREQ(NREQ), .ROUNDS_A(RA), .ROUNDS_B(RB)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .bus       (bus),
        .busy      (busy),
        .sess_open (sess_open),
        .err       (err),
        .err_clr   (err_clr),
        .irq_en    (irq_en),
        .irq_ack   (irq_ack),
        .irq_pend  (irq_pend),
        .irq       (irq)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_err    = 0;

    // Session-level reference model.
    bit              m_sess;
    int              m_owner;
    bit              m_err;
    logic [NREQ-1:0] m_pend;
    bit              g_ack_done;

    task automatic apply_reset();
        bus.req_valid = '0;
        bus.req_op    = '0;
        err_clr = 1'b0;
        irq_ack = '0;
        ARESET  = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        ARESET  = 1'b0;
        m_sess = 0; m_owner = 0; m_err = 0; m_pend = '0;
        @(negedge ACLK); #1;
    endtask

    // Issue one job from requester r and follow it cycle by cycle.
    task automatic do_job(input int r, input int op);
        logic [NREQ-1:0]  oh;
        logic [SEL_W-1:0] rs;
        logic [VW-1:0]    obs, exp_v;
        logic [3+NREQ:0]  obs_s, exp_s;
        int n, w;
        bit errp, clr;
        oh = '0; oh[r] = 1'b1;
        rs = SEL_W'(r);
        clr = err_clr;
        bus.req_valid[r]        = 1'b1;
        bus.req_op[2*r +: 2]    = op[1:0];
        #1;
        w = 0;
        while (bus.req_ready == '0 && w < 40) begin
            @(negedge ACLK); #1;
            w++;
        end
        n_checks++;
        if (bus.req_ready !== oh) begin
            n_err++;
            $display("FAIL grant r=%0d op=%0d: got %b want %b", r, op, bus.req_ready, oh);
            bus.req_valid[r] = 1'b0;
            err_clr = 1'b0;
            return;
        end
        errp = !m_sess && op != 0;
        n    = (op == 0 || op == 3) ? RA : RB;
        @(posedge ACLK); #1;
        bus.req_valid[r] = 1'b0;
        err_clr = 1'b0;
        @(negedge ACLK); #1;
        if (!errp) begin
            obs   = {bus.req_ready, bus.perm_load, bus.perm_en, bus.perm_rc_idx, bus.done, bus.perm_sel};
            exp_v = {{NREQ{1'b0}}, 1'b1, 1'b0, 4'd0, {NREQ{1'b0}}, rs};
            n_checks++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL load r=%0d op=%0d: got %h want %h", r, op, obs, exp_v);
            end
            for (int k = 0; k < n; k++) begin
                @(negedge ACLK); #1;
                obs   = {bus.req_ready, bus.perm_load, bus.perm_en, bus.perm_rc_idx, bus.done, bus.perm_sel};
                exp_v = {{NREQ{1'b0}}, 1'b0, 1'b1, 4'(12 - n + k), {NREQ{1'b0}}, rs};
                n_checks++;
                if (obs !== exp_v) begin
                    n_err++;
                    $display("FAIL round%0d r=%0d op=%0d: got %h want %h", k, r, op, obs, exp_v);
                end
            end
            @(negedge ACLK); #1;
        end
        obs   = {bus.req_ready, bus.perm_load, bus.perm_en, bus.perm_rc_idx, bus.done, bus.perm_sel};
        exp_v = {{NREQ{1'b0}}, 1'b0, 1'b0, 4'd0, oh, rs};
        n_checks++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL done r=%0d op=%0d err=%0d: got %h want %h", r, op, errp, obs, exp_v);
        end
        irq_ack = g_ack_done ? oh : '0;
        if (clr) m_err = 0;
        if (errp) m_err = 1;
        if (!m_sess && op == 0) begin m_sess = 1; m_owner = r; end
        if (g_ack_done) m_pend[r] = 1'b0;
        if (op == 3) begin m_sess = 0; m_pend[r] = 1'b1; end
        @(posedge ACLK); #1;
        irq_ack = '0;
        @(negedge ACLK); #1;
        obs_s = {busy, sess_open, err, 1'b0, irq_pend};
        exp_s = {1'b0, m_sess, m_err, 1'b0, m_pend};
        n_checks++;
        if (obs_s !== exp_s) begin
            n_err++;
            $display("FAIL idle r=%0d op=%0d: got %b want %b", r, op, obs_s, exp_s);
        end
    endtask

    task automatic test_reset();
        logic [VW+NREQ+3:0] obs;
        apply_reset();
        obs = {bus.req_ready, bus.perm_load, bus.perm_en, bus.perm_rc_idx, bus.done, bus.perm_sel,
               busy, sess_open, err, irq, irq_pend};
        n_checks++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0", obs);
        end
    endtask

    task automatic test_arbitration();
        bus.req_valid[1]  = 1'b1;
        bus.req_op[3:2]   = 2'd0;
        do_job(0, 0);
        do_job(0, 3);
        bus.req_valid[0]  = 1'b1;
        bus.req_op[1:0]   = 2'd0;
        do_job(1, 0);
        bus.req_valid[0]  = 1'b0;
        do_job(1, 3);
        irq_ack = '1;
        @(posedge ACLK); #1;
        irq_ack = '0;
        m_pend  = '0;
        @(negedge ACLK); #1;
        n_checks++;
        if (irq_pend !== '0) begin
            n_err++;
            $display("FAIL irq_ack_clear: got %b want 0", irq_pend);
        end
    endtask

    task automatic test_init_msg();
        irq_en = 2'b01;
        do_job(0, 0);
        do_job(0, 2);
        n_checks++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq_after_msg: got %b want 0", irq);
        end
    endtask

    task automatic test_stall_final();
        bus.req_valid[1] = 1'b1;
        bus.req_op[3:2]  = 2'd0;
        do_job(0, 3);
        n_checks++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq_lag: got %b want 0", irq);
        end
        do_job(1, 0);
        n_checks++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("FAIL irq_level: got %b want 1", irq);
        end
        g_ack_done = 1;
        do_job(1, 3);
        g_ack_done = 0;
        irq_ack = '1;
        @(posedge ACLK); #1;
        irq_ack = '0;
        m_pend  = '0;
        @(negedge ACLK); #1;
    endtask

    task automatic test_err();
        err_clr = 1'b1;
        do_job(1, 1);
        err_clr = 1'b1;
        @(posedge ACLK); #1;
        err_clr = 1'b0;
        m_err   = 0;
        @(negedge ACLK); #1;
        n_checks++;
        if (err !== 1'b0) begin
            n_err++;
            $display("FAIL err_clr: got %b want 0", err);
        end
    endtask

    task automatic test_random();
        int r, op;
        for (int i = 0; i < 24; i++) begin
            irq_en     = NREQ'($urandom);
            g_ack_done = $urandom_range(0, 1);
            r  = m_sess ? m_owner : int'($urandom_range(0, NREQ - 1));
            op = int'($urandom_range(0, 3));
            do_job(r, op);
        end
        g_ack_done = 0;
        if (m_sess) do_job(m_owner, 3);
        @(negedge ACLK); #1;
        n_checks++;
        if (irq !== |(m_pend & irq_en)) begin
            n_err++;
            $display("FAIL irq_random: got %b want %b", irq, |(m_pend & irq_en));
        end
    endtask

    task automatic test_reset_mid();
        logic [VW+NREQ+3:0] obs;
        logic [4:0] rnd;
        bit seen;
        int w;
        bus.req_valid[0] = 1'b1;
        bus.req_op[1:0]  = 2'd0;
        #1;
        w = 0;
        while (bus.req_ready == '0 && w < 40) begin
            @(negedge ACLK); #1;
            w++;
        end
        @(posedge ACLK); #1;
        bus.req_valid[0] = 1'b0;
        repeat (6) @(negedge ACLK);
        #1;
        rnd = {bus.perm_en, bus.perm_rc_idx};
        n_checks++;
        if (rnd !== 5'h14) begin
            n_err++;
            $display("FAIL round5_before_reset: got %h want 14", rnd);
        end
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(negedge ACLK); #1;
        obs = {bus.req_ready, bus.perm_load, bus.perm_en, bus.perm_rc_idx, bus.done, bus.perm_sel,
               busy, sess_open, err, irq, irq_pend};
        n_checks++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got %h want 0", obs);
        end
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge ACLK); #1;
            if (bus.done !== '0 || irq_pend !== '0 || irq !== 1'b0) seen = 1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_silent: got %b want 0", seen);
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_op    = '0;
        g_ack_done    = 0;
        test_reset();
        test_arbitration();
        test_init_msg();
        test_stall_final();
        test_err();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ascon_perm_sched.md
# ascon_perm_sched

Session-locking scheduler that shares one ASCON permutation datapath between NREQ requesters (e.g. AXI-Lite register front-end and a DMA engine). It grants a requester ownership for a full AEAD session (INIT … FINAL), sequences load and round-enable strobes with the correct round-constant indices, and raises a per-requester completion interrupt. It sits between the slave interfaces and the permutation core inside ascon_core.

## Interface
- NREQ, 2, number of requesters (2..4)
- ROUNDS_A, 12, rounds for INIT/FINAL (p^a), ≤12
- ROUNDS_B, 6, rounds for AD/MSG (p^b), ≤ROUNDS_A
- ACLK  in  1  clock, rising edge
- ARESET  in  1  reset, synchronous and active-high
- req_valid  in  NREQ  job request per requester, held until accepted
- req_op  in  2*NREQ  op per requester: 0 INIT, 1 AD, 2 MSG, 3 FINAL
- req_ready  out  NREQ  one-hot accept strobe; handshake when valid&ready
- done  out  NREQ  one-cycle completion pulse to the job's requester
- perm_sel  out  clog2(NREQ)  owner index; muxes state source into core
- perm_load  out  1  one-cycle load of owner's state/block into core
- perm_en  out  1  advance one permutation round
- perm_rc_idx  out  4  round-constant index for current round
- busy  out  1  high in any state but IDLE
- sess_open  out  1  a session owner is locked
- err  out  1  sticky: non-INIT job accepted with no open session
- err_clr  in  1  clears err
- irq_en  in  NREQ  per-requester interrupt enable
- irq_ack  in  NREQ  write-1-clear of pending bits
- irq_pend  out  NREQ  sticky FINAL-complete flags
- irq  out  1  |(irq_pend & irq_en), active-high level

## Operation
- States: IDLE, LOAD, ROUND, DONE.
- IDLE eligibility: session open → only owner's request eligible (any op); no session → any requester eligible; among eligible, round-robin starting at rr_ptr.
- Grant in IDLE: req_ready[g]=1 for one cycle, latch g→perm_sel, latch op. INIT with no session: open session, owner=g. Non-INIT with no session: set err, go to DONE directly (no load, no rounds).
- INIT while session already open is treated as a normal job by owner (restart); no error.
- LOAD: perm_load=1, one cycle.
- ROUND: perm_en=1 every cycle for N rounds (N=ROUNDS_A for INIT/FINAL, ROUNDS_B otherwise); perm_rc_idx = 12−N + cnt, cnt 0..N−1; 4-bit counter, no wrap.
- DONE: done[owner]=1 one cycle. If op FINAL: close session, set irq_pend[owner], rr_ptr = owner+1 mod NREQ. Return to IDLE.
- irq_pend set and irq_ack same cycle same bit → set wins.
- err_clr and new err same cycle → err stays 1.
- Requests from non-owners while session open stall (no error).

## Timing
- Reset: state IDLE, all outputs 0, sess_open=0, rr_ptr=0, irq_pend=0, err=0. Reset mid-session aborts job silently: no done, no irq.
- Accept cycle T; LOAD T+1; rounds T+2..T+N+1; done T+N+2; next accept earliest T+N+3. INIT latency 14 cycles, AD/MSG 8 (defaults).
- req_ready never asserted outside IDLE; at most one bit high.
- irq follows irq_pend/irq_en with one register stage: irq_pend set at DONE edge, irq high the following cycle.
- perm_sel stable from accept through DONE.

## Structure
- Package ascon_sched_pkg: op_e (INIT, AD, MSG, FINAL), state_e, ROUNDS_A/B defaults, rc-index helper function.
- Sub-module rr_arbiter (NREQ requests, eligibility mask, rr_ptr in, one-hot grant out, combinational).
- Scheduler FSM, round counter and interrupt register in ascon_perm_sched.

## Test plan
- Req0 INIT at accept T → perm_load at T+1, perm_en T+2..T+13 with rc_idx 0..11, done[0] at T+14, sess_open=1.
- Req0 MSG after INIT → 6 rounds, rc_idx 6..11, done[0] at T+8; irq stays 0.
- Session owned by 0, req1 INIT held valid → req1 stalled until req0 FINAL done; irq_pend=01, irq=1 if irq_en[0]; req1 accepted next IDLE cycle.
- Both INIT simultaneously from reset → req0 granted; after its FINAL, both INIT again → req1 granted (rr_ptr=1).
- Req1 AD with no session → accepted, err=1, done[1] next cycle, no perm_load/perm_en; err_clr → err=0.
- ARESET asserted during ROUND round 5 → next cycle all outputs 0, sess_open=0, no done pulse.
